if_pc_ctrl: RTL and testbench

IF_PC_CTRL -- requirements
Module: if_pc_ctrl

---
 rtl/if_pc_ctrl_pkg.sv | 19 +
 rtl/sat_cnt16.sv | 40 ++++
 rtl/if_pc_ctrl.sv | 158 +++++++++++++++
 tb/tb_if_pc_ctrl.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/if_pc_ctrl_pkg.sv
// Shared CPU front-end package.
// Holds the fetch FSM state encoding, the sequential PC increment and the
// performance-counter width used by if_pc_ctrl and sat_cnt16.
package if_pc_ctrl_pkg;

  // Fetch FSM states.
  typedef enum logic [1:0] {
    StRun       = 2'b00,
    StHold      = 2'b01,
    StRedirPend = 2'b10
  } fetch_state_e;

  // Byte distance between sequential instructions.
  localparam int unsigned PcIncr = 4;

  // Width of the performance counters.
  localparam int unsigned CntW = 16;

endpackage : if_pc_ctrl_pkg

// File: rtl/sat_cnt16.sv
// Saturating up-counter for front-end performance statistics.
// Ports:
//   clk_i  - clock, counts on the rising edge
//   rst_ni - asynchronous active-low reset, clears the count
//   en_i   - count this cycle
//   clr_i  - synchronous clear, wins over en_i
//   cnt_o  - current count, sticks at all-ones
module sat_cnt16
  import if_pc_ctrl_pkg::*;
(
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            en_i,
  input  logic            clr_i,
  output logic [CntW-1:0] cnt_o
);

  logic [CntW-1:0] cnt_q;
  logic [CntW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule : sat_cnt16

// File: rtl/if_pc_ctrl.sv
// Instruction-fetch PC controller.
// Sequences the fetch PC, holds the front end on hazards/stalls, and handles
// taken branches resolved in ID, including a redirect that is not granted
// by instruction memory immediately.
// Ports:
//   clk, reset_n                 - clock, asynchronous active-low reset
//   ID_br_ctrl, ID_br_target     - taken branch and its target from ID
//   br_hazard_stall, pipe_stall  - hold requests (either one holds fetch)
//   imem_gnt                     - imem accepts imem_addr this cycle
//   imem_req, imem_addr          - fetch request and address
//   IF_valid                     - returned instruction is valid for IF/ID
//   IF_ID_stall, IF_ID_flush     - hold / squash the IF/ID register
//   stall_cnt, br_taken_cnt      - saturating hold and redirect counts
module if_pc_ctrl
  import if_pc_ctrl_pkg::*;
#(
  parameter int unsigned         PC_W     = 32,
  parameter logic [0:PC_W-1]     RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            ID_br_ctrl,
  input  logic            br_hazard_stall,
  input  logic [0:PC_W-1] ID_br_target,
  input  logic            pipe_stall,
  input  logic            imem_gnt,
  output logic            imem_req,
  output logic [0:PC_W-1] imem_addr,
  output logic            IF_valid,
  output logic            IF_ID_stall,
  output logic            IF_ID_flush,
  output logic [CntW-1:0] stall_cnt,
  output logic [CntW-1:0] br_taken_cnt
);

  fetch_state_e    state_q, state_d;
  logic [0:PC_W-1] pc_q, pc_d;
  logic [0:PC_W-1] redir_q, redir_d;
  logic            valid_q, valid_d;

  logic            hold;
  logic [0:PC_W-1] br_tgt;

  assign hold   = br_hazard_stall | pipe_stall;
  // Bit PC_W-1 is the LSB; instructions are word aligned.
  assign br_tgt = {ID_br_target[0:PC_W-3], 2'b00};

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    redir_d     = redir_q;
    valid_d     = 1'b0;
    imem_req    = 1'b0;
    imem_addr   = pc_q;
    IF_ID_stall = 1'b0;
    IF_ID_flush = 1'b0;

    unique case (state_q)
      StRun: begin
        if (hold) begin
          // Hold beats a same-cycle branch; the branch is seen again later.
          IF_ID_stall = 1'b1;
          state_d     = StHold;
        end else if (ID_br_ctrl) begin
          // The fetch at pc_q this cycle is wrong-path, so it never
          // produces IF_valid.
          imem_req    = 1'b1;
          IF_ID_flush = 1'b1;
          redir_d     = br_tgt;
          if (imem_gnt) begin
            pc_d = br_tgt;
          end else begin
            state_d = StRedirPend;
          end
        end else begin
          imem_req = 1'b1;
          if (imem_gnt) begin
            pc_d    = pc_q + PC_W'(PcIncr);
            valid_d = 1'b1;
          end
        end
      end

      StHold: begin
        if (hold) begin
          IF_ID_stall = 1'b1;
        end else if (ID_br_ctrl) begin
          // Branch resolved as the hold lifts: nothing is in flight, so
          // point the PC at the target and fetch it from RUN.
          IF_ID_flush = 1'b1;
          redir_d     = br_tgt;
          pc_d        = br_tgt;
          state_d     = StRun;
        end else begin
          state_d = StRun;
        end
      end

      StRedirPend: begin
        imem_addr = redir_q;
        if (hold) begin
          IF_ID_stall = 1'b1;
        end else begin
          imem_req = 1'b1;
          if (imem_gnt) begin
            pc_d    = redir_q + PC_W'(PcIncr);
            valid_d = 1'b1;
            state_d = StRun;
          end
        end
      end

      default: begin
        state_d = StRun;
      end
    endcase

    // Keep handshake outputs quiet for the whole reset assertion.
    if (!reset_n) begin
      imem_req    = 1'b0;
      IF_ID_stall = 1'b0;
      IF_ID_flush = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StRun;
      pc_q    <= RESET_PC;
      redir_q <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      redir_q <= redir_d;
      valid_q <= valid_d;
    end
  end

  assign IF_valid = valid_q;

  sat_cnt16 u_stall_cnt (
    .clk_i  (clk),
    .rst_ni (reset_n),
    .en_i   (IF_ID_stall),
    .clr_i  (1'b0),
    .cnt_o  (stall_cnt)
  );

  sat_cnt16 u_br_taken_cnt (
    .clk_i  (clk),
    .rst_ni (reset_n),
    .en_i   (IF_ID_flush),
    .clr_i  (1'b0),
    .cnt_o  (br_taken_cnt)
  );

endmodule : if_pc_ctrl

// File: tb/tb_if_pc_ctrl.sv
module tb_if_pc_ctrl;

  logic        clk;
  logic        reset_n;
  logic        ID_br_ctrl;
  logic        br_hazard_stall;
  logic [0:31] ID_br_target;
  logic        pipe_stall;
  logic        imem_gnt;
  logic        imem_req;
  logic [0:31] imem_addr;
  logic        IF_valid;
  logic        IF_ID_stall;
  logic        IF_ID_flush;
  logic [15:0] stall_cnt;
  logic [15:0] br_taken_cnt;

  int checks = 0;
  int errors = 0;

  if_pc_ctrl #(
    .PC_W     (32),
    .RESET_PC (32'h0000_0000)
  ) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .ID_br_ctrl      (ID_br_ctrl),
    .br_hazard_stall (br_hazard_stall),
    .ID_br_target    (ID_br_target),
    .pipe_stall      (pipe_stall),
    .imem_gnt        (imem_gnt),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .IF_valid        (IF_valid),
    .IF_ID_stall     (IF_ID_stall),
    .IF_ID_flush     (IF_ID_flush),
    .stall_cnt       (stall_cnt),
    .br_taken_cnt    (br_taken_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    reset_n         = 1'b0;
    ID_br_ctrl      = 1'b0;
    br_hazard_stall = 1'b0;
    pipe_stall      = 1'b0;
    imem_gnt        = 1'b0;
    ID_br_target    = '0;
    next_cycle();
    next_cycle();
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n         = 1'b0;
    ID_br_ctrl      = 1'b1;
    br_hazard_stall = 1'b1;
    pipe_stall      = 1'b0;
    imem_gnt        = 1'b1;
    ID_br_target    = 32'h100;
    next_cycle();
    @(negedge clk);
    checks++; if (imem_req !== 1'b0) begin errors++;
      $display("FAIL rst_req: got %b want 0", imem_req); end
    checks++; if (IF_ID_stall !== 1'b0 || IF_ID_flush !== 1'b0) begin errors++;
      $display("FAIL rst_stall_flush: got %b%b want 00", IF_ID_stall, IF_ID_flush); end
    checks++; if (IF_valid !== 1'b0) begin errors++;
      $display("FAIL rst_valid: got %b want 0", IF_valid); end
    checks++; if (stall_cnt !== 16'h0 || br_taken_cnt !== 16'h0) begin errors++;
      $display("FAIL rst_cnt: got %h/%h want 0/0", stall_cnt, br_taken_cnt); end
    next_cycle();
    ID_br_ctrl      = 1'b0;
    br_hazard_stall = 1'b0;
    reset_n         = 1'b1;
    @(negedge clk);
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin errors++;
      $display("FAIL first_req: got req=%b addr=%h want 1/0", imem_req, imem_addr); end
  endtask

  task automatic test_sequential();
    reset_dut();
    imem_gnt = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checks++; if (imem_addr !== 32'(4 * k) || imem_req !== 1'b1) begin errors++;
        $display("FAIL seq_addr%0d: got %h want %h", k, imem_addr, 32'(4 * k)); end
      checks++; if (IF_valid !== (k >= 1)) begin errors++;
        $display("FAIL seq_valid%0d: got %b want %b", k, IF_valid, (k >= 1)); end
      next_cycle();
    end
  endtask

  task automatic test_stall();
    reset_dut();
    imem_gnt = 1'b1;
    repeat (4) next_cycle();
    // PC is now 0x10.
    br_hazard_stall = 1'b1;
    for (int s = 0; s < 3; s++) begin
      @(negedge clk);
      checks++; if (IF_ID_stall !== 1'b1 || imem_req !== 1'b0 || imem_addr !== 32'h10)
        begin errors++;
        $display("FAIL stall%0d: got stall=%b req=%b addr=%h want 1/0/10",
                 s, IF_ID_stall, imem_req, imem_addr); end
      next_cycle();
    end
    br_hazard_stall = 1'b0;
    @(negedge clk);
    checks++; if (IF_ID_stall !== 1'b0 || imem_addr !== 32'h10) begin errors++;
      $display("FAIL stall_release: got stall=%b addr=%h want 0/10", IF_ID_stall, imem_addr); end
    next_cycle();
    @(negedge clk);
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h10) begin errors++;
      $display("FAIL stall_refetch: got req=%b addr=%h want 1/10", imem_req, imem_addr); end
    next_cycle();
    @(negedge clk);
    checks++; if (imem_addr !== 32'h14) begin errors++;
      $display("FAIL stall_next: got %h want 14", imem_addr); end
    checks++; if (stall_cnt !== 16'd3) begin errors++;
      $display("FAIL stall_cnt: got %0d want 3", stall_cnt); end
    next_cycle();
  endtask

  task automatic test_branch_taken();
    reset_dut();
    imem_gnt = 1'b1;
    next_cycle();
    ID_br_ctrl   = 1'b1;
    ID_br_target = 32'h203;  // low bits must be dropped
    @(negedge clk);
    checks++; if (IF_ID_flush !== 1'b1 || imem_addr !== 32'h4) begin errors++;
      $display("FAIL br_flush: got flush=%b addr=%h want 1/4", IF_ID_flush, imem_addr); end
    next_cycle();
    ID_br_ctrl = 1'b0;
    @(negedge clk);
    checks++; if (IF_ID_flush !== 1'b0 || imem_addr !== 32'h200) begin errors++;
      $display("FAIL br_target: got flush=%b addr=%h want 0/200", IF_ID_flush, imem_addr); end
    checks++; if (IF_valid !== 1'b0) begin errors++;
      $display("FAIL br_squash_valid: got %b want 0", IF_valid); end
    checks++; if (br_taken_cnt !== 16'd1) begin errors++;
      $display("FAIL br_cnt: got %0d want 1", br_taken_cnt); end
    next_cycle();
    @(negedge clk);
    checks++; if (imem_addr !== 32'h204 || IF_valid !== 1'b1) begin errors++;
      $display("FAIL br_after: got addr=%h valid=%b want 204/1", imem_addr, IF_valid); end
    next_cycle();
  endtask

  task automatic test_branch_pending();
    reset_dut();
    imem_gnt = 1'b1;
    next_cycle();
    imem_gnt     = 1'b0;
    ID_br_ctrl   = 1'b1;
    ID_br_target = 32'h300;
    @(negedge clk);
    checks++; if (IF_ID_flush !== 1'b1) begin errors++;
      $display("FAIL pend_flush: got %b want 1", IF_ID_flush); end
    next_cycle();
    // A second branch while pending must be ignored.
    ID_br_target = 32'h500;
    @(negedge clk);
    checks++; if (imem_addr !== 32'h300 || imem_req !== 1'b1 || IF_ID_flush !== 1'b0)
      begin errors++;
      $display("FAIL pend_addr: got addr=%h req=%b flush=%b want 300/1/0",
               imem_addr, imem_req, IF_ID_flush); end
    checks++; if (IF_valid !== 1'b0) begin errors++;
      $display("FAIL pend_valid: got %b want 0", IF_valid); end
    next_cycle();
    ID_br_ctrl = 1'b0;
    imem_gnt   = 1'b1;
    @(negedge clk);
    checks++; if (imem_addr !== 32'h300 || IF_valid !== 1'b0) begin errors++;
      $display("FAIL pend_gnt: got addr=%h valid=%b want 300/0", imem_addr, IF_valid); end
    next_cycle();
    @(negedge clk);
    checks++; if (imem_addr !== 32'h304 || IF_valid !== 1'b1) begin errors++;
      $display("FAIL pend_exit: got addr=%h valid=%b want 304/1", imem_addr, IF_valid); end
    checks++; if (br_taken_cnt !== 16'd1) begin errors++;
      $display("FAIL pend_cnt: got %0d want 1", br_taken_cnt); end
    next_cycle();
  endtask

  task automatic test_stall_vs_branch();
    reset_dut();
    imem_gnt = 1'b1;
    next_cycle();
    br_hazard_stall = 1'b1;
    ID_br_ctrl      = 1'b1;
    ID_br_target    = 32'h400;
    @(negedge clk);
    checks++; if (IF_ID_flush !== 1'b0 || IF_ID_stall !== 1'b1 || imem_addr !== 32'h4)
      begin errors++;
      $display("FAIL svb_same: got flush=%b stall=%b addr=%h want 0/1/4",
               IF_ID_flush, IF_ID_stall, imem_addr); end
    next_cycle();
    br_hazard_stall = 1'b0;
    ID_br_ctrl      = 1'b0;
    @(negedge clk);
    checks++; if (IF_ID_flush !== 1'b0 || imem_addr !== 32'h4) begin errors++;
      $display("FAIL svb_hold: got flush=%b addr=%h want 0/4", IF_ID_flush, imem_addr); end
    next_cycle();
    @(negedge clk);
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h4 || br_taken_cnt !== 16'd0)
      begin errors++;
      $display("FAIL svb_resume: got req=%b addr=%h cnt=%0d want 1/4/0",
               imem_req, imem_addr, br_taken_cnt); end
    next_cycle();
  endtask

  task automatic test_wrap();
    reset_dut();
    imem_gnt     = 1'b1;
    ID_br_ctrl   = 1'b1;
    ID_br_target = 32'hFFFF_FFFC;
    next_cycle();
    ID_br_ctrl = 1'b0;
    @(negedge clk);
    checks++; if (imem_addr !== 32'hFFFF_FFFC) begin errors++;
      $display("FAIL wrap_pre: got %h want fffffffc", imem_addr); end
    next_cycle();
    @(negedge clk);
    checks++; if (imem_addr !== 32'h0) begin errors++;
      $display("FAIL wrap: got %h want 0", imem_addr); end
    next_cycle();
  endtask

  task automatic test_reset_in_pend();
    reset_dut();
    imem_gnt     = 1'b0;
    ID_br_ctrl   = 1'b1;
    ID_br_target = 32'h300;
    next_cycle();
    ID_br_ctrl = 1'b0;
    @(negedge clk);
    checks++; if (imem_addr !== 32'h300) begin errors++;
      $display("FAIL rip_pend: got %h want 300", imem_addr); end
    #2;
    reset_n = 1'b0;
    #1;
    checks++; if (imem_req !== 1'b0 || IF_ID_flush !== 1'b0 || imem_addr !== 32'h0)
      begin errors++;
      $display("FAIL rip_async: got req=%b flush=%b addr=%h want 0/0/0",
               imem_req, IF_ID_flush, imem_addr); end
    next_cycle();
    reset_n  = 1'b1;
    imem_gnt = 1'b1;
    @(negedge clk);
    checks++; if (imem_addr !== 32'h0 || IF_ID_flush !== 1'b0 || imem_req !== 1'b1)
      begin errors++;
      $display("FAIL rip_after: got addr=%h flush=%b req=%b want 0/0/1",
               imem_addr, IF_ID_flush, imem_req); end
    next_cycle();
    @(negedge clk);
    checks++; if (imem_addr !== 32'h4 || br_taken_cnt !== 16'd0) begin errors++;
      $display("FAIL rip_next: got addr=%h cnt=%0d want 4/0", imem_addr, br_taken_cnt); end
    next_cycle();
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_stall();
    test_branch_taken();
    test_branch_pending();
    test_stall_vs_branch();
    test_wrap();
    test_reset_in_pend();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_if_pc_ctrl
